// File: rtl/pipe_sync_types_pkg.sv
// Shared types for the pipeline synchronisation sequencer (fence_wfi_ctrl).
package pipe_sync_types_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DFLUSH   = 3'd1,
        S_IINV     = 3'd2,
        S_WFI_WAIT = 3'd3,
        S_RETIRE   = 3'd4,
        S_HALTED   = 3'd5
    } sync_state_t;

    localparam int WFI_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/fence_wfi_ctrl_wfi_timer.sv
// wfi_timer: saturating WFI cycle counter with a forced-wake compare.
module wfi_timer #(
    parameter int WFI_TIMEOUT = 0,
    parameter int CNT_W       = 16
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic             TMO_EN   = (WFI_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(WFI_TIMEOUT - 1) : {CNT_W{1'b0}};

    logic [CNT_W-1:0] r_cnt;

    // Cycle counter: cleared on WFI entry, counts while waiting, holds at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clear) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_enable && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = TMO_EN && (r_cnt == TMO_LAST);

endmodule

// File: rtl/fence_wfi_ctrl.sv
// fence_wfi_ctrl: sequences FENCE.I, WFI and HALT in the execute stage.
// Define FENCEI_CACHE_MAINT_EN to run the D-cache flush / I-cache invalidate handshakes on FENCE.I.
module fence_wfi_ctrl
    import pipe_sync_types_pkg::*;
#(
    parameter int WFI_TIMEOUT = 0,
    parameter int WFI_CNT_W   = WFI_CNT_W_DEFAULT
) (
    input  logic CLK,
    input  logic nRST,
    input  logic ex_valid,
    input  logic ifence,
    input  logic wfi,
    input  logic halt,
    input  logic interrupt_pending,
    output logic dcache_flush_req,
    input  logic dcache_flush_done,
    output logic icache_inv_req,
    input  logic icache_inv_done,
    output logic stall_pipe,
    output logic flush_fetch,
    output logic insn_done,
    output logic busy,
    output logic halted
);

`ifdef FENCEI_CACHE_MAINT_EN
    localparam sync_state_t FENCE_ENTRY = S_DFLUSH;
    localparam logic        CACHE_MAINT = 1'b1;
`else
    // Cacheless build: FENCE.I only needs the fetch squash in RETIRE.
    localparam sync_state_t FENCE_ENTRY = S_RETIRE;
    localparam logic        CACHE_MAINT = 1'b0;
    logic w_unused_done;
    assign w_unused_done = dcache_flush_done ^ icache_inv_done;
`endif

    sync_state_t r_state;
    sync_state_t w_state_next;
    logic        r_is_fence;
    logic        w_is_fence_next;
    logic        w_trig;
    logic        w_timer_clear;
    logic        w_timer_en;
    logic        w_wfi_expired;

    assign w_trig     = ex_valid & (halt | ifence | wfi);
    assign w_timer_en = (r_state == S_WFI_WAIT);

    wfi_timer #(
        .WFI_TIMEOUT (WFI_TIMEOUT),
        .CNT_W       (WFI_CNT_W)
    ) u_wfi_timer (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_wfi_expired)
    );

    // State register and fence flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_is_fence <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_is_fence <= w_is_fence_next;
        end
    end

    // Next-state logic; triggers are only looked at in IDLE.
    always_comb begin
        w_state_next    = r_state;
        w_is_fence_next = r_is_fence;
        w_timer_clear   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_trig) begin
                    w_state_next = S_IDLE;
                end else if (halt) begin
                    w_state_next = S_HALTED;
                end else if (ifence) begin
                    w_state_next    = FENCE_ENTRY;
                    w_is_fence_next = 1'b1;
                end else begin
                    w_state_next    = S_WFI_WAIT;
                    w_is_fence_next = 1'b0;
                    w_timer_clear   = 1'b1;
                end
            end
`ifdef FENCEI_CACHE_MAINT_EN
            S_DFLUSH: begin
                if (dcache_flush_done) begin
                    w_state_next = S_IINV;
                end else begin
                    w_state_next = S_DFLUSH;
                end
            end
            S_IINV: begin
                if (icache_inv_done) begin
                    w_state_next = S_RETIRE;
                end else begin
                    w_state_next = S_IINV;
                end
            end
`else
            S_DFLUSH: w_state_next = S_IDLE;
            S_IINV:   w_state_next = S_IDLE;
`endif
            S_WFI_WAIT: begin
                if (interrupt_pending || w_wfi_expired) begin
                    w_state_next = S_RETIRE;
                end else begin
                    w_state_next = S_WFI_WAIT;
                end
            end
            S_RETIRE: w_state_next = S_IDLE;
            S_HALTED: w_state_next = S_HALTED;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Moore outputs, except the zero-latency stall on the trigger cycle.
    always_comb begin
        stall_pipe       = 1'b0;
        dcache_flush_req = 1'b0;
        icache_inv_req   = 1'b0;
        flush_fetch      = 1'b0;
        insn_done        = 1'b0;
        busy             = 1'b1;
        halted           = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_pipe = w_trig;
                busy       = 1'b0;
            end
            S_DFLUSH: begin
                stall_pipe       = 1'b1;
                dcache_flush_req = CACHE_MAINT;
            end
            S_IINV: begin
                stall_pipe     = 1'b1;
                icache_inv_req = CACHE_MAINT;
            end
            S_WFI_WAIT: stall_pipe = 1'b1;
            S_RETIRE: begin
                insn_done   = 1'b1;
                flush_fetch = r_is_fence;
            end
            S_HALTED: begin
                stall_pipe = 1'b1;
                halted     = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fence_wfi_ctrl.sv
// Self-checking bench for fence_wfi_ctrl: two instances (no timeout, timeout 8) driven in parallel.
module tb_fence_wfi_ctrl;

`ifdef FENCEI_CACHE_MAINT_EN
    localparam bit CM = 1'b1;
`else
    localparam bit CM = 1'b0;
`endif

    // Output vector: {stall, dreq, ireq, flush, done, busy, halted}
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_TRIG = 7'b1000000;
    localparam logic [6:0] O_DFL  = 7'b1100010;
    localparam logic [6:0] O_IINV = 7'b1010010;
    localparam logic [6:0] O_WAIT = 7'b1000010;
    localparam logic [6:0] O_RETF = 7'b0001110;
    localparam logic [6:0] O_RETW = 7'b0000110;
    localparam logic [6:0] O_HALT = 7'b1000011;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ex_valid = 1'b0, ifence = 1'b0, wfi = 1'b0, halt = 1'b0;
    logic interrupt_pending = 1'b0, dcache_flush_done = 1'b0, icache_inv_done = 1'b0;
    logic dreq_a, ireq_a, stall_a, flush_a, done_a, busy_a, halted_a;
    logic dreq_b, ireq_b, stall_b, flush_b, done_b, busy_b, halted_b;
    logic [13:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    fence_wfi_ctrl #(.WFI_TIMEOUT(0), .WFI_CNT_W(16)) u_dut_a (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ifence(ifence), .wfi(wfi), .halt(halt),
        .interrupt_pending(interrupt_pending),
        .dcache_flush_req(dreq_a), .dcache_flush_done(dcache_flush_done),
        .icache_inv_req(ireq_a), .icache_inv_done(icache_inv_done),
        .stall_pipe(stall_a), .flush_fetch(flush_a), .insn_done(done_a), .busy(busy_a), .halted(halted_a)
    );

    fence_wfi_ctrl #(.WFI_TIMEOUT(8), .WFI_CNT_W(16)) u_dut_b (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ifence(ifence), .wfi(wfi), .halt(halt),
        .interrupt_pending(interrupt_pending),
        .dcache_flush_req(dreq_b), .dcache_flush_done(dcache_flush_done),
        .icache_inv_req(ireq_b), .icache_inv_done(icache_inv_done),
        .stall_pipe(stall_b), .flush_fetch(flush_b), .insn_done(done_b), .busy(busy_b), .halted(halted_b)
    );

    function automatic logic [13:0] outs();
        return {stall_a, dreq_a, ireq_a, flush_a, done_a, busy_a, halted_a,
                stall_b, dreq_b, ireq_b, flush_b, done_b, busy_b, halted_b};
    endfunction

    // Called at posedge+1: drive {ex_valid,ifence,wfi,halt,irq,ddone,idone}, sample at negedge.
    task automatic run_cycle(input logic [6:0] stim, output logic [13:0] got);
        {ex_valid, ifence, wfi, halt, interrupt_pending, dcache_flush_done, icache_inv_done} = stim;
        @(negedge CLK);
        got = outs();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        #1;
        got = outs();
        n_checks++;
        if (got !== 14'd0) begin
            n_errors++;
            $display("FAIL reset_idle got %b expected %b", got, 14'd0);
        end
        ex_valid = 1'b1; wfi = 1'b1;
        #1;
        got = outs();
        n_checks++;
        if (got !== {O_TRIG, O_TRIG}) begin
            n_errors++;
            $display("FAIL reset_trig_stall got %b expected %b", got, {O_TRIG, O_TRIG});
        end
        ex_valid = 1'b0; wfi = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_fence_fast();
        logic [13:0] got, e;
        logic [6:0] s, x;
        int ret;
        ret = CM ? 3 : 1;
        for (int c = 0; c < 6; c++) begin
            s = {(c <= ret), (c <= ret), 1'b0, 1'b0, 1'b0, (c == 1), (c == 2)};
            if (c == 0) x = O_TRIG;
            else if (c == ret) x = O_RETF;
            else if (c > ret) x = O_IDLE;
            else if (c == 1) x = O_DFL;
            else x = O_IINV;
            exp_q.push_back({x, x});
            run_cycle(s, got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL fence_fast cycle %0d got %b expected %b", c, got, e);
            end
        end
    endtask

    task automatic test_fence_slow();
        logic [13:0] got, e;
        logic [6:0] s, x;
        int ret;
        ret = CM ? 23 : 1;
        for (int c = 0; c < 26; c++) begin
            s = {(c <= ret), (c <= ret), 1'b0, 1'b0, 1'b0, (c == 20), (c == 5 || c == 22)};
            if (c == 0) x = O_TRIG;
            else if (c == ret) x = O_RETF;
            else if (c > ret) x = O_IDLE;
            else if (c <= 20) x = O_DFL;
            else x = O_IINV;
            exp_q.push_back({x, x});
            run_cycle(s, got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL fence_slow cycle %0d got %b expected %b", c, got, e);
            end
        end
    endtask

    // irq_at: cycle interrupt_pending rises in WFI_WAIT; instance B also wakes on its timeout.
    task automatic test_wfi(input string name, input int irq_at, input int n);
        logic [13:0] got, e;
        logic [6:0] s, xa, xb;
        for (int c = 0; c < n; c++) begin
            s = {(c == 0), 1'b0, (c == 0), 1'b0, (c >= irq_at && c <= irq_at + 1), 1'b0, 1'b0};
            if (c == 0) xa = O_TRIG;
            else if (c <= irq_at || c == 1) xa = O_WAIT;
            else if (c == irq_at + 1 || (irq_at == 0 && c == 2)) xa = O_RETW;
            else xa = O_IDLE;
            if (c == 0) xb = O_TRIG;
            else if (irq_at < 8 && (c <= irq_at || c == 1)) xb = O_WAIT;
            else if (irq_at < 8 && (c == irq_at + 1 || (irq_at == 0 && c == 2))) xb = O_RETW;
            else if (irq_at >= 8 && c <= 8) xb = O_WAIT;
            else if (irq_at >= 8 && c == 9) xb = O_RETW;
            else xb = O_IDLE;
            exp_q.push_back({xa, xb});
            run_cycle(s, got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL %s cycle %0d got %b expected %b", name, c, got, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] got, e;
        logic [6:0] s, x;
        for (int c = 0; c < 4; c++) begin
            s = CM ? {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (c == 1), 1'b0}
                   : {(c == 0), 1'b0, (c == 0), 1'b0, 1'b0, 1'b0, 1'b0};
            if (c == 0) x = O_TRIG;
            else if (CM && c == 1) x = O_DFL;
            else if (CM) x = O_IINV;
            else x = O_WAIT;
            exp_q.push_back({x, x});
            run_cycle(s, got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL reset_mid_pre cycle %0d got %b expected %b", c, got, e);
            end
        end
        {ex_valid, ifence, wfi, halt, interrupt_pending, dcache_flush_done, icache_inv_done} = 7'd0;
        nRST = 1'b0;
        #1;
        got = outs();
        n_checks++;
        if (got !== 14'd0) begin
            n_errors++;
            $display("FAIL reset_mid_async got %b expected %b", got, 14'd0);
        end
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        test_wfi("wfi_after_reset", 2, 5);
    endtask

    task automatic test_halt();
        logic [13:0] got, e;
        logic [6:0] s, x;
        for (int c = 0; c < 101; c++) begin
            s = {1'b1, 1'b1, 1'b0, 1'b1, (c % 7 == 3), (c % 3 == 1), (c % 3 == 2)};
            x = (c == 0) ? O_TRIG : O_HALT;
            exp_q.push_back({x, x});
            run_cycle(s, got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL halt cycle %0d got %b expected %b", c, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fence_fast();
        test_fence_slow();
        test_wfi("wfi_irq_early", 0, 4);
        test_wfi("wfi_irq_50", 50, 53);
        test_wfi("wfi_timeout", 20, 23);
        test_reset_mid();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
